// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, port ids and latency constants for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, LATCH, RESP} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int ACCESS_RD_LAT = 3;
  localparam int ACCESS_WR_LAT = 2;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester and syncram bus of mem_arbiter
//   i_*   : instruction-fetch read port (req/addr in, rdata/ready out)
//   d_*   : load/store port (req/we/addr/wdata in, rdata/ready out)
//   ram_* : syncram strobes (cs/oe/we/addr/din out, dout in)
//   busy  : arbiter not idle
//   slave modport is the arbiter view, master the surrounding system view
interface mem_arb_if #(parameter int AW = 32, parameter int DW = 32);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          ram_cs;
  logic          ram_oe;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
    output i_rdata, i_ready, d_rdata, d_ready, ram_cs, ram_oe, ram_we, ram_addr, ram_din, busy
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
    input  i_rdata, i_ready, d_rdata, d_ready, ram_cs, ram_oe, ram_we, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between I and D requesters
//   in : i_req, d_req, last_grant   out: grant_valid, grant_port
//   MEM_ARB_RR_EN defined: round-robin on contention, else fixed D>I priority
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_port
);
  assign grant_valid = i_req | d_req;
`ifdef MEM_ARB_RR_EN
  // on contention the port that did not win last time goes next
  assign grant_port = (i_req & d_req) ? ~last_grant : (d_req ? PORT_D : PORT_I);
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_port = d_req ? PORT_D : PORT_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one syncram between I-fetch and load/store ports
//   clk, rst_n (async active-low), bus (mem_arb_if.slave: requester and RAM signals)
//   optional MEM_ARB_RR_EN selects round-robin arbitration in arb_pick
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic      clk,
  input logic      rst_n,
  mem_arb_if.slave bus
);
  state_t state;
  logic   owner;
  logic   last_grant;
  logic   grant_valid;
  logic   grant_port;
  arb_pick u_pick (
    .i_req       (bus.i_req),
    .d_req       (bus.d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= PORT_I;
      last_grant   <= PORT_D;
      bus.i_rdata  <= {DW{1'b0}};
      bus.d_rdata  <= {DW{1'b0}};
      bus.i_ready  <= 1'b0;
      bus.d_ready  <= 1'b0;
      bus.ram_cs   <= 1'b0;
      bus.ram_oe   <= 1'b0;
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= {AW{1'b0}};
      bus.ram_din  <= {DW{1'b0}};
    end else begin
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      case (state)
        IDLE: if (grant_valid) begin
          state        <= ACCESS;
          owner        <= grant_port;
          last_grant   <= grant_port;
          bus.ram_cs   <= 1'b1;
          bus.ram_oe   <= grant_port == PORT_D ? ~bus.d_we : 1'b1;
          bus.ram_we   <= grant_port == PORT_D ? bus.d_we : 1'b0;
          bus.ram_addr <= grant_port == PORT_D ? bus.d_addr : bus.i_addr;
          bus.ram_din  <= grant_port == PORT_D ? bus.d_wdata : {DW{1'b0}};
        end
        ACCESS: begin
          // RAM acts on this edge; writes are done, reads need one more cycle for dout
          state      <= bus.ram_we ? RESP : LATCH;
          bus.ram_cs <= 1'b0;
          bus.ram_oe <= 1'b0;
          bus.ram_we <= 1'b0;
          if (bus.ram_we) bus.d_ready <= 1'b1;
        end
        LATCH: begin
          state <= RESP;
          if (owner == PORT_D) begin
            bus.d_rdata <= bus.ram_dout;
            bus.d_ready <= 1'b1;
          end else begin
            bus.i_rdata <= bus.ram_dout;
            bus.i_ready <= 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
